openriscv_mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port instruction/data memory of the openrisc SoPC between instruction fetch (m0) and load/store (m1).
- Sits between the core's fetch/LSU ports and the memory port.
- Supports memory back-pressure, one-cycle read latency, response routing, anti-starvation for fetch, and a lock for atomic read-modify-write sequences.

---
 rtl/openriscv_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_openriscv_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/openriscv_mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch (m0)
// and load/store (m1), with fetch anti-starvation, an m1 lock and one-cycle read routing.
module openriscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic [DW-1:0]   mem_rdata
);

  // Handshake: a requester holds req and its fields stable until it sees gnt;
  // gnt is high only in a cycle where the arbiter selects it and mem_gnt is high.

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  sel_t       winner;
  sel_t       rsp_owner;
  sel_t       rsp_next;
  logic       lock_held;
  logic       lock_next;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;

  // Gating winner with rst forces every combinational output low during reset.
  always_comb begin
    winner = SEL_NONE;
    if (rst) begin
      winner = SEL_NONE;
    end else if (lock_held) begin
      if (m1_req) winner = SEL_M1;
    end else if (m0_req && m1_req) begin
      winner = (starve_cnt == STARVE_LIM) ? SEL_M0 : SEL_M1;
    end else if (m0_req) begin
      winner = SEL_M0;
    end else if (m1_req) begin
      winner = SEL_M1;
    end
  end

  assign m0_gnt  = (winner == SEL_M0) && mem_gnt;
  assign m1_gnt  = (winner == SEL_M1) && mem_gnt;
  assign mem_req = (winner != SEL_NONE);

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (winner)
      SEL_M0: begin
        mem_be   = '1;
        mem_addr = m0_addr;
      end
      SEL_M1: begin
        mem_we    = m1_we;
        mem_be    = m1_be;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // Fetch loses only count while unlocked; stall cycles grant nothing and so hold.
  always_comb begin
    starve_next = starve_cnt;
    if (m0_gnt)
      starve_next = '0;
    else if (m0_req && m1_gnt && !lock_held && (starve_cnt != STARVE_LIM))
      starve_next = starve_cnt + 4'd1;

    lock_next = lock_held;
    if (m1_gnt) lock_next = m1_lock;

    rsp_next = SEL_NONE;
    if (m0_gnt)
      rsp_next = SEL_M0;
    else if (m1_gnt && !m1_we)
      rsp_next = SEL_M1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner  <= SEL_NONE;
      lock_held  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_owner  <= rsp_next;
      lock_held  <= lock_next;
      starve_cnt <= starve_next;
    end
  end

  assign m0_rvalid = (rsp_owner == SEL_M0);
  assign m1_rvalid = (rsp_owner == SEL_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_openriscv_mem_arbiter.sv
// Self-checking bench for openriscv_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_openriscv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]    m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_req, mem_we, mem_gnt;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit         md_lock;
  int         md_starve;
  logic [1:0] exp_q[$];   // master id (1=m0, 2=m1) whose read data is due next cycle
  bit         e_m0_gnt, e_m1_gnt;

  openriscv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sample at the falling edge; expectations come from the model and current inputs.
  task automatic eval();
    int w;
    int rsp;
    @(negedge clk);
    if (rst) begin
      md_lock = 0;
      md_starve = 0;
      exp_q.delete();
    end
    w = 0;
    if (!rst) begin
      if (md_lock) w = m1_req ? 2 : 0;
      else if (m0_req && m1_req) w = (md_starve == STARVE_MAX) ? 1 : 2;
      else if (m0_req) w = 1;
      else if (m1_req) w = 2;
    end
    e_m0_gnt = (w == 1) && mem_gnt;
    e_m1_gnt = (w == 2) && mem_gnt;
    rsp = 0;
    if (!rst && exp_q.size() > 0) rsp = int'(exp_q.pop_front());

    check("m0_gnt", 64'(m0_gnt), 64'(e_m0_gnt));
    check("m1_gnt", 64'(m1_gnt), 64'(e_m1_gnt));
    check("mem_req", 64'(mem_req), 64'(w != 0));
    if (w == 1) begin
      check("mem_we_m0", 64'(mem_we), 64'd0);
      check("mem_be_m0", 64'(mem_be), 64'hF);
      check("mem_addr_m0", 64'(mem_addr), 64'(m0_addr));
    end else if (w == 2) begin
      check("mem_we_m1", 64'(mem_we), 64'(m1_we));
      check("mem_be_m1", 64'(mem_be), 64'(m1_be));
      check("mem_addr_m1", 64'(mem_addr), 64'(m1_addr));
      check("mem_wdata_m1", 64'(mem_wdata), 64'(m1_wdata));
    end else if (rst) begin
      check("rst_mem_fields", {mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
    end
    check("m0_rvalid", 64'(m0_rvalid), 64'(rsp == 1));
    check("m0_rdata", 64'(m0_rdata), (rsp == 1) ? 64'(mem_rdata) : 64'd0);
    check("m1_rvalid", 64'(m1_rvalid), 64'(rsp == 2));
    check("m1_rdata", 64'(m1_rdata), (rsp == 2) ? 64'(mem_rdata) : 64'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst) begin
      if (e_m0_gnt) begin
        md_starve = 0;
        exp_q.push_back(2'd1);
      end else if (m0_req && e_m1_gnt && !md_lock && md_starve < STARVE_MAX) begin
        md_starve++;
      end
      if (e_m1_gnt) begin
        md_lock = m1_lock;
        if (!m1_we) exp_q.push_back(2'd2);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    mem_gnt = 1'b1; mem_rdata = '0;

    // reset with both requesting: everything low
    eval();
    check("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    adv();
    rst = 1'b0;

    // single m1 read
    m0_req = 1'b0; m1_addr = 32'h10;
    eval();
    check("t1_m1_gnt", 64'(m1_gnt), 64'd1);
    adv();
    m1_req = 1'b0; mem_rdata = 32'h12345678;
    eval();
    check("t1_m1_rvalid", 64'(m1_rvalid), 64'd1);
    check("t1_m1_rdata", 64'(m1_rdata), 64'h12345678);
    check("t1_m0_rvalid", 64'(m0_rvalid), 64'd0);
    adv();

    // continuous contention: four m1 grants then one m0 grant
    m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200;
    for (int i = 0; i < 10; i++) begin
      mem_rdata = $urandom;
      eval();
      check("t2_pat_m0", 64'(m0_gnt), 64'((i % 5) == 4));
      check("t2_pat_m1", 64'(m1_gnt), 64'((i % 5) != 4));
      adv();
    end

    // locked sequence: two locked reads, unlocking write; m0 blocked throughout
    m1_lock = 1'b1; m1_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin m1_we = 1'b1; m1_lock = 1'b0; m1_wdata = 32'h55AA55AA; end
      eval();
      check("t3_m0_blocked", 64'(m0_gnt), 64'd0);
      check("t3_m1_gnt", 64'(m1_gnt), 64'd1);
      adv();
    end
    m1_req = 1'b0; m1_we = 1'b0;
    eval();
    check("t3_m0_after_unlock", 64'(m0_gnt), 64'd1);
    adv();

    // memory stall during an m0 read
    m0_addr = 32'h40; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("t4_stall_req", 64'(mem_req), 64'd1);
      check("t4_stall_addr", 64'(mem_addr), 64'h40);
      check("t4_stall_gnt", 64'(m0_gnt), 64'd0);
      adv();
    end
    mem_gnt = 1'b1;
    eval();
    check("t4_gnt", 64'(m0_gnt), 64'd1);
    adv();
    m0_req = 1'b0; mem_rdata = 32'hCAFEF00D;
    eval();
    check("t4_rvalid", 64'(m0_rvalid), 64'd1);
    check("t4_rdata", 64'(m0_rdata), 64'hCAFEF00D);
    adv();

    // m1 partial write
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 32'h80; m1_wdata = 32'hDEADBEEF;
    eval();
    check("t5_we", 64'(mem_we), 64'd1);
    check("t5_be", 64'(mem_be), 64'h3);
    check("t5_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    adv();
    m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'hF;
    eval();
    check("t5_no_rv0", 64'(m0_rvalid), 64'd0);
    check("t5_no_rv1", 64'(m1_rvalid), 64'd0);
    adv();

    // reset right after an m0 read grant drops the response
    m0_req = 1'b1; m0_addr = 32'h44;
    eval();
    check("t6_gnt", 64'(m0_gnt), 64'd1);
    adv();
    rst = 1'b1; m0_req = 1'b0;
    eval();
    check("t6_rv_in_rst", 64'(m0_rvalid), 64'd0);
    adv();
    rst = 1'b0;
    eval();
    check("t6_rv_after", 64'(m0_rvalid), 64'd0);
    adv();

    // randomized traffic; requests hold until granted
    m0_req = 1'b0; m1_req = 1'b0; e_m0_gnt = 0; e_m1_gnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (!m0_req || e_m0_gnt) begin
        m0_req  = ($urandom_range(0, 3) != 0);
        m0_addr = $urandom;
      end
      if (!m1_req || e_m1_gnt) begin
        m1_req   = ($urandom_range(0, 3) != 0);
        m1_we    = $urandom_range(0, 1) != 0;
        m1_be    = 4'($urandom_range(0, 15));
        m1_addr  = $urandom;
        m1_wdata = $urandom;
        m1_lock  = ($urandom_range(0, 3) == 0);
      end
      mem_gnt   = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      eval();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
